ltc2311_sample_scheduler: RTL and testbench

Sequences the LTC2311 reader block: issues read strobes at a programmed sample period, runs bursts of N samples or continuous capture, and manages sleep/wake power-down between bursts. Captured samples go out on a one-entry valid/ready output register with overrun and timeout reporting. Sits between the system-side control/stream logic and the reader's read/sleep/wake/data_out/data_valid/busy interface.

---
 rtl/ltc2311_pkg.sv | 16 +
 rtl/ltc2311_sample_buf.sv | 50 +++++
 rtl/ltc2311_sample_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_ltc2311_sample_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2311_pkg.sv
// Shared types for the LTC2311 sample scheduler: scheduler state encoding and
// the sample width carried from the reader to the output register.
package ltc2311_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAKING    = 3'd1,
        ST_ARMED     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DATA = 3'd4,
        ST_SLEEP     = 3'd5
    } sched_state_t;

endpackage

// File: rtl/ltc2311_sample_buf.sv
// One-entry output register for captured samples. A capture into a full,
// stalled register is dropped and reported on drop for one cycle.
module ltc2311_sample_buf
    import ltc2311_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cap_valid,
    input  logic [SAMPLE_W-1:0] cap_data,
    input  logic                m_ready,
    output logic [SAMPLE_W-1:0] m_data,
    output logic                m_valid,
    output logic                drop
);

    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;

    // Valid/ready: a beat transfers on any clk edge where m_valid & m_ready;
    // m_data is held stable while m_valid is high and the beat has not transferred.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop    = 1'b0;
        if (cap_valid) begin
            if (!valid_q || m_ready) begin
                data_d  = cap_data;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign m_data  = data_q;
    assign m_valid = valid_q;

endmodule

// File: rtl/ltc2311_sample_scheduler.sv
// Read/sleep/wake sequencer for the LTC2311 reader: paced read issue, burst or
// continuous capture, power-down between bursts, overrun and timeout flags.
module ltc2311_sample_scheduler
    import ltc2311_pkg::*;
#(
    parameter int PERIOD_W       = 16,
    parameter int WAKE_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          burst_len,
    input  logic                auto_sleep,
    output logic                rd_read,
    output logic                rd_sleep,
    output logic                rd_wake,
    input  logic [15:0]         rd_data,
    input  logic                rd_valid,
    input  logic                rd_busy,
    output logic [15:0]         m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                done,
    output logic                overrun,
    output logic                timeout_err,
    input  logic                clear_flags,
    output logic [2:0]          dbg_state
);

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t        state_q, state_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [7:0]          count_q, count_d;
    logic                stop_seen_q, stop_seen_d;
    logic                rd_read_q, rd_read_d;
    logic                rd_sleep_q, rd_sleep_d;
    logic                rd_wake_q, rd_wake_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;
    logic                capture;
    logic                tmo_evt;
    logic                drop;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = (period_cnt_q != '0) ? period_cnt_q - PERIOD_W'(1) : '0;
        wake_cnt_d   = wake_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        count_d      = count_q;
        stop_seen_d  = stop_seen_q;
        rd_sleep_d   = 1'b0;
        rd_wake_d    = 1'b0;
        done_d       = 1'b0;
        capture      = 1'b0;
        tmo_evt      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ARMED;
                    count_d      = 8'd0;
                    period_cnt_d = '0;
                end
            end
            ST_SLEEP: begin
                if (start) begin
                    state_d      = ST_WAKING;
                    rd_wake_d    = 1'b1;
                    wake_cnt_d   = WAKE_W'(WAKE_CYCLES - 1);
                    count_d      = 8'd0;
                    period_cnt_d = '0;
                    stop_seen_d  = stop;
                end
            end
            ST_WAKING: begin
                // The wake pulse occupies the first WAKE_CYCLES cycle, so the
                // first read lands exactly WAKE_CYCLES after rd_wake.
                stop_seen_d = stop_seen_q | stop;
                if (wake_cnt_q <= WAKE_W'(1)) begin
                    if (stop_seen_q || stop) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else begin
                    wake_cnt_d = wake_cnt_q - WAKE_W'(1);
                end
            end
            ST_ARMED: begin
                if (stop) begin
                    done_d     = 1'b1;
                    rd_sleep_d = auto_sleep;
                    state_d    = auto_sleep ? ST_SLEEP : ST_IDLE;
                end else if (period_cnt_q <= PERIOD_W'(1) && !rd_busy) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Counter holds cycles left after this one; expiry is seen one
                // cycle early in ARMED so ISSUE lands exactly period cycles apart.
                period_cnt_d = (period > PERIOD_W'(1)) ? period - PERIOD_W'(1) : '0;
                tmo_cnt_d    = TMO_W'(1);
                state_d      = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (rd_valid) begin
                    capture = 1'b1;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    if (stop || (burst_len != 8'd0 && (count_q + 8'd1) == burst_len)) begin
                        done_d     = 1'b1;
                        rd_sleep_d = auto_sleep;
                        state_d    = auto_sleep ? ST_SLEEP : ST_IDLE;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end else if (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES)) begin
                    tmo_evt = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rd_read_d = (state_d == ST_ISSUE);
        overrun_d = (overrun_q & ~clear_flags) | drop;
        timeout_d = (timeout_q & ~clear_flags) | tmo_evt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            period_cnt_q <= '0;
            wake_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            count_q      <= 8'd0;
            stop_seen_q  <= 1'b0;
            rd_read_q    <= 1'b0;
            rd_sleep_q   <= 1'b0;
            rd_wake_q    <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            wake_cnt_q   <= wake_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            count_q      <= count_d;
            stop_seen_q  <= stop_seen_d;
            rd_read_q    <= rd_read_d;
            rd_sleep_q   <= rd_sleep_d;
            rd_wake_q    <= rd_wake_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    ltc2311_sample_buf u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .cap_valid (capture),
        .cap_data  (rd_data),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .drop      (drop)
    );

    assign rd_read     = rd_read_q;
    assign rd_sleep    = rd_sleep_q;
    assign rd_wake     = rd_wake_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ltc2311_sample_scheduler.sv
// Directed bench for ltc2311_sample_scheduler with a fixed-latency reader model.
module tb_ltc2311_sample_scheduler;
    import ltc2311_pkg::*;

    localparam int LAT = 20;

    logic        clk = 1'b0;
    logic        reset_n, start, stop, auto_sleep, m_ready, clear_flags;
    logic [15:0] period;
    logic [7:0]  burst_len;
    logic        rd_read, rd_sleep, rd_wake, rd_valid, rd_busy;
    logic [15:0] rd_data = 16'h0;
    logic [15:0] m_data;
    logic        m_valid, done, overrun, timeout_err;
    logic [2:0]  dbg_state;

    logic        model_valid = 1'b0;
    logic        model_busy  = 1'b0;
    logic        late_valid  = 1'b0;
    logic        model_never = 1'b0;
    bit          pend        = 1'b0;
    int          wait_left   = 0;
    int          serviced    = 0;
    int          busy_viol   = 0;
    logic [15:0] data_tab [4] = '{16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hC0DE};

    int          cyc = 0;
    int          read_cyc_q[$];
    int          done_cyc_q[$];
    int          sleep_cyc_q[$];
    int          wake_cyc_q[$];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    assign rd_valid = model_valid | late_valid;
    assign rd_busy  = model_busy;

    ltc2311_sample_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .period      (period),
        .burst_len   (burst_len),
        .auto_sleep  (auto_sleep),
        .rd_read     (rd_read),
        .rd_sleep    (rd_sleep),
        .rd_wake     (rd_wake),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_busy     (rd_busy),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .done        (done),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clear_flags (clear_flags),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reader model: rd_valid exactly LAT cycles after the rd_read cycle
    always @(negedge clk) begin
        model_valid = 1'b0;
        if (pend) begin
            wait_left--;
            if (wait_left == 0) begin
                pend        = 1'b0;
                model_busy  = 1'b0;
                model_valid = 1'b1;
                rd_data     = data_tab[serviced % 4];
                serviced++;
            end
        end
        if (rd_read && reset_n) begin
            if (pend) busy_viol++;
            if (!model_never) begin
                pend       = 1'b1;
                wait_left  = LAT;
                model_busy = 1'b1;
            end
        end
    end

    // monitor: records what the DUT sees on each active edge
    always @(posedge clk) begin
        if (reset_n) begin
            if (rd_read)            read_cyc_q.push_back(cyc);
            if (done)               done_cyc_q.push_back(cyc);
            if (rd_sleep)           sleep_cyc_q.push_back(cyc);
            if (rd_wake)            wake_cyc_q.push_back(cyc);
            if (m_valid && m_ready) got_q.push_back(m_data);
        end
        cyc++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (done_cyc_q.size() < target && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(done_cyc_q.size() >= target), 32'd1);
    endtask

    task automatic wait_reads(input int target, input int max_cyc, input string tag);
        int n = 0;
        while (read_cyc_q.size() < target && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(read_cyc_q.size() >= target), 32'd1);
    endtask

    task automatic wait_mvalid(input int max_cyc, input string tag);
        int n = 0;
        while (!m_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(m_valid), 32'd1);
    endtask

    function automatic int rd_at(input int i);
        if (i < read_cyc_q.size()) return read_cyc_q[i];
        return -1;
    endfunction

    function automatic int dn_at(input int i);
        if (i < done_cyc_q.size()) return done_cyc_q[i];
        return -1;
    endfunction

    function automatic int got_at(input int i);
        if (i < got_q.size()) return int'(got_q[i]);
        return -1;
    endfunction

    function automatic logic [31:0] outs_vec();
        return {6'd0, m_data, m_valid, done, overrun, timeout_err,
                rd_read, rd_sleep, rd_wake, dbg_state};
    endfunction

    initial begin
        int rb, db, gb, sb, slb, wb, d;

        reset_n = 1'b0; start = 1'b0; stop = 1'b0; period = 16'd0;
        burst_len = 8'd0; auto_sleep = 1'b0; m_ready = 1'b1; clear_flags = 1'b0;
        repeat (3) tick();
        check_eq("reset_outputs", outs_vec(), 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: period 50, burst 4, fixed model data
        period = 16'd50; burst_len = 8'd4; auto_sleep = 1'b0; m_ready = 1'b1;
        rb = read_cyc_q.size(); db = done_cyc_q.size(); gb = got_q.size();
        pulse_start();
        wait_done(db + 1, 400, "t1_done_seen");
        repeat (2) tick();
        check_eq("t1_reads", 32'(read_cyc_q.size() - rb), 32'd4);
        for (int i = 1; i < 4; i++)
            check_eq("t1_spacing", 32'(rd_at(rb + i) - rd_at(rb + i - 1)), 32'd50);
        check_eq("t1_done_lat", 32'(dn_at(db) - rd_at(rb + 3)), 32'd21);
        exp_q.push_back(16'hDEAD); exp_q.push_back(16'hBEEF);
        exp_q.push_back(16'hDEAD); exp_q.push_back(16'hC0DE);
        for (int i = 0; i < 4; i++) check_eq("t1_data", 32'(got_at(gb + i)), 32'(exp_q.pop_front()));
        check_eq("t1_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t1_overrun", 32'(overrun), 32'd0);

        // 2: period shorter than conversion
        period = 16'd5; burst_len = 8'd3;
        rb = read_cyc_q.size(); db = done_cyc_q.size(); gb = got_q.size(); sb = serviced;
        pulse_start();
        wait_done(db + 1, 300, "t2_done_seen");
        repeat (2) tick();
        check_eq("t2_reads", 32'(read_cyc_q.size() - rb), 32'd3);
        for (int i = 1; i < 3; i++) begin
            d = rd_at(rb + i) - rd_at(rb + i - 1);
            check_eq("t2_spacing_21_22", 32'(d >= 21 && d <= 22), 32'd1);
        end
        check_eq("t2_busy_viol", 32'(busy_viol), 32'd0);
        check_eq("t2_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back(data_tab[(sb + i) % 4]);
        for (int i = 0; i < 3; i++) check_eq("t2_data", 32'(got_at(gb + i)), 32'(exp_q.pop_front()));

        // 3: auto sleep then wake
        period = 16'd50; burst_len = 8'd2; auto_sleep = 1'b1;
        db = done_cyc_q.size(); slb = sleep_cyc_q.size();
        pulse_start();
        wait_done(db + 1, 300, "t3_done_seen");
        tick();
        check_eq("t3_sleep_cnt", 32'(sleep_cyc_q.size() - slb), 32'd1);
        check_eq("t3_sleep_with_done", 32'((slb < sleep_cyc_q.size()) ? sleep_cyc_q[slb] : -1), 32'(dn_at(db)));
        check_eq("t3_state_sleep", 32'(dbg_state), 32'(ST_SLEEP));
        auto_sleep = 1'b0;
        rb = read_cyc_q.size(); db = done_cyc_q.size(); wb = wake_cyc_q.size();
        pulse_start();
        wait_reads(rb + 1, 200, "t3_first_read_seen");
        check_eq("t3_wake_cnt", 32'(wake_cyc_q.size() - wb), 32'd1);
        check_eq("t3_wake_to_read", 32'(rd_at(rb) - ((wb < wake_cyc_q.size()) ? wake_cyc_q[wb] : 0)), 32'd64);
        wait_done(db + 1, 300, "t3_done2_seen");
        tick();
        check_eq("t3_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t3_no_sleep2", 32'(sleep_cyc_q.size() - slb), 32'd1);

        // 4: stalled consumer, overrun
        period = 16'd30; burst_len = 8'd3; m_ready = 1'b0;
        db = done_cyc_q.size(); gb = got_q.size(); sb = serviced;
        pulse_start();
        wait_mvalid(100, "t4_first_valid");
        check_eq("t4_overrun_pre", 32'(overrun), 32'd0);
        check_eq("t4_data1", 32'(m_data), 32'(data_tab[sb % 4]));
        wait_done(db + 1, 300, "t4_done_seen");
        tick();
        check_eq("t4_data_held", 32'(m_data), 32'(data_tab[sb % 4]));
        check_eq("t4_valid_held", 32'(m_valid), 32'd1);
        check_eq("t4_overrun", 32'(overrun), 32'd1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check_eq("t4_overrun_clr", 32'(overrun), 32'd0);
        m_ready = 1'b1;
        tick();
        check_eq("t4_valid_drained", 32'(m_valid), 32'd0);
        check_eq("t4_got", 32'(got_at(gb)), 32'(data_tab[sb % 4]));

        // 5: reader never answers
        model_never = 1'b1; period = 16'd0; burst_len = 8'd1;
        rb = read_cyc_q.size(); db = done_cyc_q.size();
        pulse_start();
        wait_done(db + 1, 400, "t5_done_seen");
        tick();
        check_eq("t5_timeout_lat", 32'(dn_at(db) - rd_at(rb)), 32'd257);
        check_eq("t5_timeout_err", 32'(timeout_err), 32'd1);
        check_eq("t5_state", 32'(dbg_state), 32'(ST_IDLE));
        late_valid = 1'b1;
        tick();
        late_valid = 1'b0;
        tick();
        check_eq("t5_late_ignored", 32'(m_valid), 32'd0);
        check_eq("t5_state_after_late", 32'(dbg_state), 32'(ST_IDLE));
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check_eq("t5_timeout_clr", 32'(timeout_err), 32'd0);
        model_never = 1'b0;

        // 6: continuous capture, stop mid-conversion
        period = 16'd30; burst_len = 8'd0;
        rb = read_cyc_q.size(); db = done_cyc_q.size(); gb = got_q.size(); sb = serviced;
        pulse_start();
        wait_reads(rb + 2, 200, "t6_two_reads");
        repeat (5) tick();
        stop = 1'b1;
        wait_done(db + 1, 100, "t6_done_seen");
        stop = 1'b0;
        repeat (60) tick();
        check_eq("t6_reads", 32'(read_cyc_q.size() - rb), 32'd2);
        check_eq("t6_done_lat", 32'(dn_at(db) - rd_at(rb + 1)), 32'd21);
        check_eq("t6_samples", 32'(got_q.size() - gb), 32'd2);
        check_eq("t6_data2", 32'(got_at(gb + 1)), 32'(data_tab[(sb + 1) % 4]));
        check_eq("t6_state", 32'(dbg_state), 32'(ST_IDLE));

        // 7: reset while waiting for data
        m_ready = 1'b0;
        rb = read_cyc_q.size();
        pulse_start();
        wait_reads(rb + 2, 200, "t7_two_reads");
        repeat (5) tick();
        check_eq("t7_valid_before", 32'(m_valid), 32'd1);
        check_eq("t7_state_wait", 32'(dbg_state), 32'(ST_WAIT_DATA));
        reset_n = 1'b0;
        tick();
        check_eq("t7_reset_outputs", outs_vec(), 32'd0);
        reset_n = 1'b1;
        repeat (30) tick();
        check_eq("t7_late_after_reset", 32'(m_valid), 32'd0);
        check_eq("t7_state_idle", 32'(dbg_state), 32'(ST_IDLE));

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
